// File: rtl/wb_stage.sv
// Writeback stage: a single pipeline latch between MEM and the register file.
// It selects the write-back data and forwards the in-flight write to the
// decode-stage read ports. It also keeps a sticky HALT flag and a saturating
// count of retired instructions.
module wb_stage (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        mem_valid,
    input  logic        mem_regwen,
    input  logic [4:0]  mem_wsel,
    input  logic [1:0]  mem_wbsrc,
    input  logic [31:0] mem_aluout,
    input  logic [31:0] mem_dload,
    input  logic [31:0] mem_npc,
    input  logic [31:0] mem_lui,
    input  logic        mem_halt,
    input  logic        wb_en,
    input  logic        wb_flush,
    input  logic [4:0]  id_rsel1,
    input  logic [4:0]  id_rsel2,
    input  logic [31:0] id_rdat1_in,
    input  logic [31:0] id_rdat2_in,
    output logic        rf_WEN,
    output logic [4:0]  rf_wsel,
    output logic [31:0] rf_wdat,
    output logic [31:0] id_rdat1,
    output logic [31:0] id_rdat2,
    output logic        halt,
    output logic [31:0] retire_cnt
);

    localparam logic [1:0]  SRC_ALU  = 2'b00;
    localparam logic [1:0]  SRC_LOAD = 2'b01;
    localparam logic [1:0]  SRC_NPC  = 2'b10;
    localparam logic [1:0]  SRC_LUI  = 2'b11;
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    // Forward the write-back value when it targets the register being read.
    function automatic logic [31:0] bypass(
        input logic        wen,
        input logic [4:0]  wsel,
        input logic [31:0] wdat,
        input logic [4:0]  rsel,
        input logic [31:0] raw
    );
        if (wen && (wsel == rsel)) begin
            bypass = wdat;
        end else begin
            bypass = raw;
        end
    endfunction

    logic        valid_q,  valid_d;
    logic        regwen_q, regwen_d;
    logic [4:0]  wsel_q,   wsel_d;
    logic [1:0]  wbsrc_q,  wbsrc_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] dload_q,  dload_d;
    logic [31:0] npc_q,    npc_d;
    logic [31:0] lui_q,    lui_d;
    logic        hflag_q,  hflag_d;
    logic        halt_q,   halt_d;
    logic [31:0] retire_q, retire_d;

    logic        halt_now_s;
    logic        capture_s;
    logic [31:0] wdat_s;
    logic        wen_s;

    // Latch next-state: flush squashes, halt blocks, stall holds, else capture.
    always_comb begin
        valid_d  = valid_q;
        regwen_d = regwen_q;
        wsel_d   = wsel_q;
        wbsrc_d  = wbsrc_q;
        aluout_d = aluout_q;
        dload_d  = dload_q;
        npc_d    = npc_q;
        lui_d    = lui_q;
        hflag_d  = hflag_q;
        // A latched HALT freezes the pipe on the same edge that raises halt,
        // so the instruction behind it can never retire.
        halt_now_s = halt_q | (valid_q & hflag_q);
        capture_s  = 1'b0;
        if (wb_flush) begin
            valid_d = 1'b0;
        end else if (halt_now_s) begin
            valid_d = 1'b0;
        end else if (wb_en) begin
            capture_s = 1'b1;
            valid_d   = mem_valid;
            regwen_d  = mem_regwen;
            wsel_d    = mem_wsel;
            wbsrc_d   = mem_wbsrc;
            aluout_d  = mem_aluout;
            dload_d   = mem_dload;
            npc_d     = mem_npc;
            lui_d     = mem_lui;
            hflag_d   = mem_halt;
        end else begin
            valid_d = valid_q;
        end
    end

    // Sticky halt and saturating retire counter next-state.
    always_comb begin
        halt_d   = halt_now_s;
        retire_d = retire_q;
        if (capture_s && mem_valid && (retire_q != CNT_MAX)) begin
            retire_d = retire_q + 32'd1;
        end else begin
            retire_d = retire_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q  <= 1'b0;
            regwen_q <= 1'b0;
            wsel_q   <= 5'd0;
            wbsrc_q  <= 2'b00;
            aluout_q <= 32'd0;
            dload_q  <= 32'd0;
            npc_q    <= 32'd0;
            lui_q    <= 32'd0;
            hflag_q  <= 1'b0;
            halt_q   <= 1'b0;
            retire_q <= 32'd0;
        end else begin
            valid_q  <= valid_d;
            regwen_q <= regwen_d;
            wsel_q   <= wsel_d;
            wbsrc_q  <= wbsrc_d;
            aluout_q <= aluout_d;
            dload_q  <= dload_d;
            npc_q    <= npc_d;
            lui_q    <= lui_d;
            hflag_q  <= hflag_d;
            halt_q   <= halt_d;
            retire_q <= retire_d;
        end
    end

    // Write-back data source select from the latched instruction.
    always_comb begin
        case (wbsrc_q)
            SRC_ALU:  wdat_s = aluout_q;
            SRC_LOAD: wdat_s = dload_q;
            SRC_NPC:  wdat_s = npc_q;
            SRC_LUI:  wdat_s = lui_q;
            default:  wdat_s = aluout_q;
        endcase
    end

    // HALT never writes, and $zero is never a write target, so it is never bypassed.
    assign wen_s = valid_q & regwen_q & ~hflag_q & (wsel_q != 5'd0);

    assign rf_WEN     = wen_s;
    assign rf_wsel    = wsel_q;
    assign rf_wdat    = wdat_s;
    assign id_rdat1   = bypass(wen_s, wsel_q, wdat_s, id_rsel1, id_rdat1_in);
    assign id_rdat2   = bypass(wen_s, wsel_q, wdat_s, id_rsel2, id_rdat2_in);
    assign halt       = halt_q;
    assign retire_cnt = retire_q;

endmodule
